// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, false-start rejection,
// 3-sample majority vote, optional parity and 1 or 2 checked stop bits.
module uart_rx_param #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 received,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_PRE  = TW'(MID - 1);
  localparam logic [TW-1:0] T_MID  = TW'(MID);
  localparam logic [TW-1:0] T_VOTE = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  localparam logic HAS_PAR  = (PARITY != 0);
  localparam logic ODD_PAR  = (PARITY == 1);
  localparam logic S_FINAL  = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [1:0]           sync;
  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic                 scnt;
  logic                 samp_a;
  logic                 samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr;
  logic                 rearm;
  logic                 voted;
  logic                 vote_pt;
  logic                 last_tick;
  logic                 parity_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], bit_in};
  end

  assign rx_s      = sync[1];
  assign voted     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign vote_pt   = (tcnt == T_VOTE);
  assign last_tick = (tcnt == T_LAST);
  assign parity_ok = ((^shreg) ^ par_bit) == ODD_PAR;
  assign busy      = (state != S_IDLE);

  // The frame completes at the vote point of the last stop bit, so a next
  // start edge arriving up to half a bit early is still caught in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      bcnt       <= '0;
      scnt       <= 1'b0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr       <= 1'b0;
      rearm      <= 1'b1;
      data_out   <= '0;
      received   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      received <= 1'b0;
      if (sample_en) begin
        if (tcnt == T_PRE) samp_a <= rx_s;
        if (tcnt == T_MID) samp_b <= rx_s;
        if (state != S_IDLE) tcnt <= last_tick ? '0 : tcnt + TW'(1);

        case (state)
          S_IDLE: begin
            tcnt <= '0;
            if (rx_s)       rearm <= 1'b1;
            else if (rearm) state <= S_START;
          end

          S_START: begin
            if ((tcnt == T_PRE && rx_s) || (vote_pt && voted)) begin
              state <= S_IDLE;
              tcnt  <= '0;
            end else if (last_tick) begin
              state <= S_DATA;
              bcnt  <= '0;
              ferr  <= 1'b0;
            end
          end

          S_DATA: begin
            if (vote_pt) begin
              for (int i = 0; i < DATA_BITS; i++)
                if (bcnt == BW'(i)) shreg[i] <= voted;
            end
            if (last_tick) begin
              bcnt <= bcnt + BW'(1);
              if (bcnt == B_LAST) begin
                state <= HAS_PAR ? S_PARITY : S_STOP;
                scnt  <= 1'b0;
              end
            end
          end

          S_PARITY: begin
            if (vote_pt) par_bit <= voted;
            if (last_tick) begin
              state <= S_STOP;
              scnt  <= 1'b0;
            end
          end

          S_STOP: begin
            if (vote_pt) begin
              if (!voted) ferr <= 1'b1;
              if (scnt == S_FINAL) begin
                data_out   <= shreg;
                parity_err <= HAS_PAR & ~parity_ok;
                frame_err  <= ferr | ~voted;
                received   <= 1'b1;
                rearm      <= ~ferr & voted;
                state      <= S_IDLE;
                tcnt       <= '0;
              end
            end else if (last_tick) begin
              scnt <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four parameterisations driven with
// hand-built frames, checking data, flags, busy and received pulse counts.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       line_a = 1'b1, line_e = 1'b1, line_o = 1'b1, line_s = 1'b1;

  logic [7:0] data_a, data_e, data_o;
  logic [6:0] data_s;
  logic [3:0] rcv, perr, ferr, busy;

  int cnt [4];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // The 7-bit receiver gets one sample_en tick every other clock.
  always @(negedge clk) tick = ~tick;

  always @(negedge clk) begin
    if (rcv[0]) cnt[0] = cnt[0] + 1;
    if (rcv[1]) cnt[1] = cnt[1] + 1;
    if (rcv[2]) cnt[2] = cnt[2] + 1;
    if (rcv[3]) cnt[3] = cnt[3] + 1;
  end

  uart_rx_param dut_def (
    .clk(clk), .rst(rst), .sample_en(1'b1), .bit_in(line_a),
    .data_out(data_a), .received(rcv[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .busy(busy[0])
  );

  uart_rx_param #(.PARITY(2)) dut_even (
    .clk(clk), .rst(rst), .sample_en(1'b1), .bit_in(line_e),
    .data_out(data_e), .received(rcv[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .busy(busy[1])
  );

  uart_rx_param #(.PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .sample_en(1'b1), .bit_in(line_o),
    .data_out(data_o), .received(rcv[2]), .parity_err(perr[2]),
    .frame_err(ferr[2]), .busy(busy[2])
  );

  uart_rx_param #(.OVERSAMPLE(8), .DATA_BITS(7), .STOP_BITS(2)) dut_seven (
    .clk(clk), .rst(rst), .sample_en(tick), .bit_in(line_s),
    .data_out(data_s), .received(rcv[3]), .parity_err(perr[3]),
    .frame_err(ferr[3]), .busy(busy[3])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setLine(input int sel, input logic v);
    case (sel)
      0: line_a = v;
      1: line_e = v;
      2: line_o = v;
      default: line_s = v;
    endcase
  endtask

  // Frame bits go out LSB (start bit) first; glitch_clk inverts the line for
  // exactly one clock at that 1-based clock index within the frame.
  task automatic applyStimulus(input int sel, input logic [23:0] frame, input int nbits,
                               input int clk_per_bit, input int glitch_clk);
    int n = 0;
    logic [23:0] fr;
    for (int b = 0; b < nbits; b++) begin
      fr = frame >> b;
      for (int t = 0; t < clk_per_bit; t++) begin
        @(negedge clk);
        n++;
        setLine(sel, fr[0] ^ (n == glitch_clk));
      end
    end
    @(negedge clk);
    setLine(sel, 1'b1);
    repeat (2 * clk_per_bit) @(negedge clk);
  endtask

  initial begin
    int c;
    logic [9:0] f;

    repeat (3) @(negedge clk);
    checkOutput("reset data_out",   32'(data_a),  32'h0);
    checkOutput("reset received",   32'(rcv[0]),  32'h0);
    checkOutput("reset parity_err", 32'(perr[0]), 32'h0);
    checkOutput("reset frame_err",  32'(ferr[0]), 32'h0);
    checkOutput("reset busy",       32'(busy),    32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    c = cnt[0];
    applyStimulus(0, 24'({1'b1, 8'hA5, 1'b0}), 10, 16, -1);
    checkOutput("a5 pulses",   32'(cnt[0] - c), 32'd1);
    checkOutput("a5 data",     32'(data_a),     32'hA5);
    checkOutput("a5 perr",     32'(perr[0]),    32'h0);
    checkOutput("a5 ferr",     32'(ferr[0]),    32'h0);
    checkOutput("a5 busy",     32'(busy[0]),    32'h0);

    // 3-clock low glitch on an idle line
    c = cnt[0];
    @(negedge clk);
    line_a = 1'b0;
    repeat (3) @(negedge clk);
    line_a = 1'b1;
    checkOutput("glitch busy high", 32'(busy[0]), 32'h1);
    repeat (8) @(negedge clk);
    checkOutput("glitch busy low",  32'(busy[0]), 32'h0);
    repeat (16) @(negedge clk);
    checkOutput("glitch pulses", 32'(cnt[0] - c), 32'd0);
    checkOutput("glitch data",   32'(data_a),     32'hA5);

    // 0x37 has five ones: even parity wants 1, odd parity wants 0
    c = cnt[1];
    applyStimulus(1, 24'({1'b1, 1'b0, 8'h37, 1'b0}), 11, 16, -1);
    checkOutput("even p0 pulses", 32'(cnt[1] - c), 32'd1);
    checkOutput("even p0 data",   32'(data_e),     32'h37);
    checkOutput("even p0 perr",   32'(perr[1]),    32'h1);
    applyStimulus(1, 24'({1'b1, 1'b1, 8'h37, 1'b0}), 11, 16, -1);
    checkOutput("even p1 perr",   32'(perr[1]),    32'h0);
    checkOutput("even p1 ferr",   32'(ferr[1]),    32'h0);
    c = cnt[2];
    applyStimulus(2, 24'({1'b1, 1'b1, 8'h37, 1'b0}), 11, 16, -1);
    checkOutput("odd p1 pulses",  32'(cnt[2] - c), 32'd1);
    checkOutput("odd p1 data",    32'(data_o),     32'h37);
    checkOutput("odd p1 perr",    32'(perr[2]),    32'h1);
    applyStimulus(2, 24'({1'b1, 1'b0, 8'hC3, 1'b0}), 11, 16, -1);
    checkOutput("odd c3 perr",    32'(perr[2]),    32'h1);
    applyStimulus(2, 24'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, 16, -1);
    checkOutput("odd c3 ok perr", 32'(perr[2]),    32'h0);
    checkOutput("odd c3 data",    32'(data_o),     32'hC3);

    // Stop bit low, then a clean frame
    c = cnt[0];
    applyStimulus(0, 24'({1'b0, 8'h5A, 1'b0}), 10, 16, -1);
    checkOutput("5a pulses", 32'(cnt[0] - c), 32'd1);
    checkOutput("5a data",   32'(data_a),     32'h5A);
    checkOutput("5a ferr",   32'(ferr[0]),    32'h1);
    applyStimulus(0, 24'({1'b1, 8'h00, 1'b0}), 10, 16, -1);
    checkOutput("00 data",   32'(data_a),     32'h00);
    checkOutput("00 ferr",   32'(ferr[0]),    32'h0);

    // One-clock inversion at the middle tick of data bit 3
    c = cnt[0];
    applyStimulus(0, 24'({1'b1, 8'hFF, 1'b0}), 10, 16, 74);
    checkOutput("vote pulses", 32'(cnt[0] - c), 32'd1);
    checkOutput("vote data",   32'(data_a),     32'hFF);

    // Break: line low for 20 bit times gives exactly one errored frame
    c = cnt[0];
    applyStimulus(0, 24'h0, 20, 16, -1);
    checkOutput("break pulses", 32'(cnt[0] - c), 32'd1);
    checkOutput("break data",   32'(data_a),     32'h00);
    checkOutput("break ferr",   32'(ferr[0]),    32'h1);
    applyStimulus(0, 24'({1'b1, 8'hC3, 1'b0}), 10, 16, -1);
    checkOutput("after break data", 32'(data_a),  32'hC3);
    checkOutput("after break ferr", 32'(ferr[0]), 32'h0);

    // Asynchronous reset in the middle of 0x81's data bits
    c = cnt[0];
    f = {1'b1, 8'h81, 1'b0};
    for (int b = 0; b < 5; b++) begin
      repeat (16) begin
        @(negedge clk);
        line_a = f[0];
      end
      f = f >> 1;
    end
    checkOutput("pre-reset busy", 32'(busy[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid reset data",  32'(data_a),  32'h0);
    checkOutput("mid reset busy",  32'(busy[0]), 32'h0);
    checkOutput("mid reset rcv",   32'(rcv[0]),  32'h0);
    checkOutput("mid reset ferr",  32'(ferr[0]), 32'h0);
    line_a = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("mid reset pulses", 32'(cnt[0] - c), 32'd0);
    applyStimulus(0, 24'({1'b1, 8'h3C, 1'b0}), 10, 16, -1);
    checkOutput("3c pulses", 32'(cnt[0] - c), 32'd1);
    checkOutput("3c data",   32'(data_a),     32'h3C);
    checkOutput("3c ferr",   32'(ferr[0]),    32'h0);

    // 7 data bits, 2 stop bits, 8 ticks per bit at half clock rate
    c = cnt[3];
    applyStimulus(3, 24'({2'b11, 7'h55, 1'b0}), 10, 16, -1);
    checkOutput("s7 55 pulses", 32'(cnt[3] - c), 32'd1);
    checkOutput("s7 55 data",   32'(data_s),     32'h55);
    checkOutput("s7 55 ferr",   32'(ferr[3]),    32'h0);
    checkOutput("s7 55 perr",   32'(perr[3]),    32'h0);
    applyStimulus(3, 24'({2'b01, 7'h2A, 1'b0}), 10, 16, -1);
    checkOutput("s7 stop2 data", 32'(data_s),  32'h2A);
    checkOutput("s7 stop2 ferr", 32'(ferr[3]), 32'h1);
    applyStimulus(3, 24'({2'b10, 7'h7F, 1'b0}), 10, 16, -1);
    checkOutput("s7 stop1 data", 32'(data_s),  32'h7F);
    checkOutput("s7 stop1 ferr", 32'(ferr[3]), 32'h1);
    applyStimulus(3, 24'({2'b11, 7'h33, 1'b0}), 10, 16, -1);
    checkOutput("s7 33 pulses", 32'(cnt[3] - c), 32'd4);
    checkOutput("s7 33 data",   32'(data_s),     32'h33);
    checkOutput("s7 33 ferr",   32'(ferr[3]),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
